// File: rtl/nwc_ctrl_pkg.sv
// Shared definitions for the twiddle-factor sequencing control.
// Holds the controller state encoding and the stage/depth counter widths.
package nwc_ctrl_pkg;

  localparam int STAGE_W = 3;
  localparam int DEPTH_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/tf_valid_pipe.sv
// Fixed-latency delay line for the twiddle read strobe.
// Ports:
//   clk     - clock
//   clr     - synchronous clear of every stage
//   din     - read strobe entering the pipe
//   dout    - read strobe delayed by LAT cycles
//   pending - a read is still travelling in a stage behind the output stage
module tf_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic pending
);

  logic [LAT-1:0] shift_q;
  logic [LAT-1:0] shift_d;

  generate
    if (LAT == 1) begin : g_one
      always_comb shift_d = din;
      // Single stage: the only stage is the output, nothing behind it.
      assign pending = 1'b0;
    end else begin : g_multi
      always_comb shift_d = {shift_q[LAT-2:0], din};
      // The output stage is excluded so a drain ends on the cycle the last
      // read is being presented, giving a drain length of exactly LAT.
      assign pending = |shift_q[LAT-2:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout = shift_q[LAT-1];

endmodule

// File: rtl/tf_seq_ctrl.sv
// Sequencer for one full transform: loads TF_gen, walks stages l=0..last_l
// with depth_m1+1 twiddle reads per stage, drains the TF_gen latency, then
// pulses done.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - request a sequence (only honoured in IDLE)
//   last_l, depth_m1    - final stage index, iterations per stage minus one
//   k2_en               - final stage uses the radix-k2 path
//   dp_ready            - datapath can accept a twiddle set this cycle
//   TF_wen, TF_ren      - TF_gen register load pulse, twiddle read strobe
//   it_depth_cnt, l     - current iteration and stage
//   LAST_STAGE          - final radix-k2 stage active
//   tf_valid            - TF_ren delayed by TF_LAT
//   busy, done          - not idle, one-cycle completion pulse
//   dbg_state           - current controller state
// Handshake: in RUN a read transfers on every cycle where dp_ready is high;
// TF_ren mirrors dp_ready there and counters move only on those cycles, so
// a low dp_ready stalls without losing or repeating a read.
module tf_seq_ctrl
  import nwc_ctrl_pkg::*;
#(
  parameter int TF_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STAGE_W-1:0] last_l,
  input  logic [DEPTH_W-1:0] depth_m1,
  input  logic               k2_en,
  input  logic               dp_ready,
  output logic               TF_wen,
  output logic               TF_ren,
  output logic [DEPTH_W-1:0] it_depth_cnt,
  output logic [STAGE_W-1:0] l,
  output logic               LAST_STAGE,
  output logic               tf_valid,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] l_q, l_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic [STAGE_W-1:0] cfg_last_q, cfg_last_d;
  logic [DEPTH_W-1:0] cfg_depth_q, cfg_depth_d;
  logic               cfg_k2_q, cfg_k2_d;
  logic               drain_pending;

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    cnt_d       = cnt_q;
    cfg_last_d  = cfg_last_q;
    cfg_depth_d = cfg_depth_q;
    cfg_k2_d    = cfg_k2_q;
    TF_wen      = 1'b0;
    TF_ren      = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        l_d   = '0;
        cnt_d = '0;
        if (start) begin
          // Configuration is frozen here for the whole sequence.
          cfg_last_d  = last_l;
          cfg_depth_d = depth_m1;
          cfg_k2_d    = k2_en;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        TF_wen  = 1'b1;
        l_d     = '0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        TF_ren = dp_ready;
        if (dp_ready) begin
          if (cnt_q < cfg_depth_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (l_q < cfg_last_q) begin
            cnt_d = '0;
            l_d   = l_q + 1'b1;
          end else begin
            // Final read: counters keep their last values through DRAIN.
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!drain_pending) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        l_d     = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      cnt_q       <= '0;
      cfg_last_q  <= '0;
      cfg_depth_q <= '0;
      cfg_k2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      cfg_last_q  <= cfg_last_d;
      cfg_depth_q <= cfg_depth_d;
      cfg_k2_q    <= cfg_k2_d;
    end
  end

  tf_valid_pipe #(
    .LAT(TF_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .clr    (rst),
    .din    (TF_ren),
    .dout   (tf_valid),
    .pending(drain_pending)
  );

  assign it_depth_cnt = cnt_q;
  assign l            = l_q;
  assign busy         = (state_q != ST_IDLE);
  assign LAST_STAGE   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                        cfg_k2_q && (l_q == cfg_last_q);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tf_seq_ctrl.sv
module tb_tf_seq_ctrl;
  import nwc_ctrl_pkg::*;

  localparam int TF_LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, start, k2_en, dp_ready;
  logic [2:0] last_l, depth_m1;
  logic       TF_wen, TF_ren, LAST_STAGE, tf_valid, busy, done;
  logic [2:0] it_depth_cnt, l, dbg_state;

  always #5 clk = ~clk;

  tf_seq_ctrl #(.TF_LAT(TF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .last_l(last_l), .depth_m1(depth_m1),
    .k2_en(k2_en), .dp_ready(dp_ready), .TF_wen(TF_wen), .TF_ren(TF_ren),
    .it_depth_cnt(it_depth_cnt), .l(l), .LAST_STAGE(LAST_STAGE),
    .tf_valid(tf_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sequence phase plus a count of accepted reads; stage/iteration are
  // derived from the read count by division, and tf_valid from a history
  // queue of read strobes.
  state_t m_mode = ST_IDLE;
  int     m_reads = 0, m_last = 0, m_dm = 0, m_k2 = 0, m_drain = 0;
  bit     hist[$];

  // Event counters observed on the DUT, used by the literal checks.
  int cnt_wen, cnt_ren, cnt_ls, cnt_done, cnt_drain, last_ren_cyc, done_cyc;

  always @(negedge clk) begin : model
    int per, e_l, e_cnt;
    bit e_ren, e_ls;
    per   = m_dm + 1;
    e_ren = (m_mode == ST_RUN) && dp_ready;
    e_l   = 0;
    e_cnt = 0;
    if (m_mode == ST_RUN) begin
      e_l   = m_reads / per;
      e_cnt = m_reads % per;
    end else if (m_mode == ST_DRAIN || m_mode == ST_DONE) begin
      e_l   = m_last;
      e_cnt = m_dm;
    end
    e_ls = (m_mode == ST_RUN || m_mode == ST_DRAIN) && (m_k2 != 0) && (e_l == m_last);

    if (chk_en) begin
      chk("state", int'(dbg_state), int'(m_mode));
      chk("TF_wen", int'(TF_wen), int'(m_mode == ST_LOAD));
      chk("TF_ren", int'(TF_ren), int'(e_ren));
      chk("l", int'(l), e_l);
      chk("it_depth_cnt", int'(it_depth_cnt), e_cnt);
      chk("LAST_STAGE", int'(LAST_STAGE), int'(e_ls));
      chk("tf_valid", int'(tf_valid), int'(hist[0]));
      chk("busy", int'(busy), int'(m_mode != ST_IDLE));
      chk("done", int'(done), int'(m_mode == ST_DONE));
      if (TF_wen) cnt_wen++;
      if (TF_ren) begin cnt_ren++; last_ren_cyc = cyc; end
      if (TF_ren && LAST_STAGE) cnt_ls++;
      if (done) begin cnt_done++; done_cyc = cyc; end
      if (dbg_state == ST_DRAIN) cnt_drain++;
    end

    if (rst) begin
      m_mode  = ST_IDLE;
      m_reads = 0;
      hist.delete();
      repeat (TF_LAT) hist.push_back(1'b0);
    end else begin
      hist.push_back(e_ren);
      void'(hist.pop_front());
      case (m_mode)
        ST_IDLE: if (start) begin
          m_last = int'(last_l); m_dm = int'(depth_m1); m_k2 = int'(k2_en);
          m_reads = 0; m_mode = ST_LOAD;
        end
        ST_LOAD: m_mode = ST_RUN;
        ST_RUN: if (e_ren) begin
          m_reads++;
          if (m_reads == (m_last + 1) * (m_dm + 1)) begin
            m_mode = ST_DRAIN; m_drain = TF_LAT;
          end
        end
        ST_DRAIN: begin
          m_drain--;
          if (m_drain == 0) m_mode = ST_DONE;
        end
        default: m_mode = ST_IDLE;
      endcase
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    cnt_wen = 0; cnt_ren = 0; cnt_ls = 0; cnt_done = 0; cnt_drain = 0;
    last_ren_cyc = 0; done_cyc = 0;
  endtask

  function automatic logic pick_ready(input int rmode, input int i);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return logic'(i % 2 == 0);
    return logic'($urandom_range(0, 3) != 0);
  endfunction

  // Runs one sequence: start in the current (or next) cycle, then keep
  // driving until done is seen. i counts cycles from the start cycle, so
  // i=2 is the first RUN cycle.
  task automatic run_seq(input int ll, input int dm, input int k2, input int rmode,
                         input bit noise_start, input bit noise_cfg, input bit now);
    bit seen;
    seen = 0;
    clear_counts();
    if (!now) begin @(posedge clk); #1; end
    start = 1'b1; last_l = 3'(ll); depth_m1 = 3'(dm); k2_en = k2[0];
    dp_ready = pick_ready(rmode, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        start = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise_cfg) begin
          last_l = 3'($urandom_range(0, 7)); depth_m1 = 3'($urandom_range(0, 7));
          k2_en = 1'($urandom_range(0, 1));
        end
        dp_ready = pick_ready(rmode, i);
      end
      #5;
      if (cnt_done != 0) begin seen = 1; break; end
    end
    if (!seen) chk("seq_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0; dp_ready = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    bit hit;
    repeat (TF_LAT) hist.push_back(1'b0);
    rst = 1'b1; start = 1'b0; last_l = '0; depth_m1 = '0; k2_en = 1'b0; dp_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    // Inputs that would otherwise launch a sequence must not matter in reset.
    start = 1'b1; dp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_l", int'(l), 0);
    chk("rst_tf_valid", int'(tf_valid), 0);
    @(posedge clk); #1;
    // First start coincides with the first cycle out of reset.
    rst = 1'b0;
    run_seq(3, 7, 1, 0, 0, 0, 1);
    chk("full_wen_count", cnt_wen, 1);
    chk("full_ren_count", cnt_ren, 32);
    chk("full_last_stage_reads", cnt_ls, 8);
    chk("full_done_count", cnt_done, 1);
    chk("full_done_after_last_ren", done_cyc - last_ren_cyc, 3);

    // Alternating dp_ready: stalls every other cycle.
    run_seq(1, 3, 0, 1, 0, 0, 0);
    chk("toggle_ren_count", cnt_ren, 8);
    chk("toggle_last_stage_reads", cnt_ls, 0);

    // Minimal sequence: a single read.
    run_seq(0, 0, 0, 0, 0, 0, 0);
    chk("min_ren_count", cnt_ren, 1);
    chk("min_last_stage_reads", cnt_ls, 0);
    chk("min_drain_cycles", cnt_drain, 2);

    // Reset mid-RUN at l=2, it_depth_cnt=5.
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; last_l = 3'd3; depth_m1 = 3'd7; k2_en = 1'b1; dp_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #5;
      if (l == 3'd2 && it_depth_cnt == 3'd4) begin hit = 1; break; end
    end
    chk("rst_mid_run_reached", int'(hit), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dp_ready = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt", int'(it_depth_cnt), 0);
    chk("mid_rst_done_count", cnt_done, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_tf_valid", int'(tf_valid), 0);
    end
    run_seq(3, 7, 1, 0, 0, 0, 0);
    chk("after_rst_ren_count", cnt_ren, 32);

    // Start pulses while busy are dropped.
    run_seq(2, 2, 1, 2, 1, 0, 0);
    chk("noise_start_done_count", cnt_done, 1);
    chk("noise_start_ren_count", cnt_ren, 9);

    // Config inputs wander mid-sequence; captured config rules.
    run_seq(3, 7, 0, 2, 0, 1, 0);
    chk("cfg_change_ren_count", cnt_ren, 32);

    // Randomized sequences.
    for (int s = 0; s < 8; s++) begin
      int ll, dm;
      ll = $urandom_range(0, 7);
      dm = $urandom_range(0, 7);
      run_seq(ll, dm, $urandom_range(0, 1), 2, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
      chk("rand_ren_count", cnt_ren, (ll + 1) * (dm + 1));
      chk("rand_wen_count", cnt_wen, 1);
      chk("rand_done_count", cnt_done, 1);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
